// File: rtl/mouse_master_sm.sv
// mouse_master_sm: host-side PS/2 mouse sequencer.
// Runs the power-up handshake (reset, self-test, optional wheel unlock,
// enable reporting) and then assembles stream-mode movement packets.
// Build option: define MOUSE_WHEEL_EN to compile in the wheel-enable
// sequence, device-ID detection and 4-byte packets.
module mouse_master_sm #(
  parameter int unsigned STARTUP_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [7:0] MOUSE_DZ,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE,
  output logic       WHEEL_MODE
);

  localparam int unsigned MAXC = (TIMEOUT_CYCLES > STARTUP_CYCLES) ? TIMEOUT_CYCLES : STARTUP_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

`ifdef MOUSE_WHEEL_EN
  localparam logic [3:0] LAST_STEP = 4'd8;
  localparam logic [3:0] ID_STEP   = 4'd7;
`else
  localparam logic [3:0] LAST_STEP = 4'd1;
`endif

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_RESP,
    ST_STREAM_B0,
    ST_STREAM_B1,
    ST_STREAM_B2,
    ST_STREAM_B3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [1:0]    resp_q, resp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          send_q, send_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [7:0]    status_q, status_d, dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
  logic          irq_q, irq_d;
  logic          done_q, done_d;
  logic          wheel_q, wheel_d;
  logic          tmo, restart, advance, rx_err;

  // Command byte issued at each initialisation step.
  function automatic logic [7:0] cmd_of(input logic [3:0] s);
`ifdef MOUSE_WHEEL_EN
    case (s)
      4'd0:    return 8'hFF;
      4'd1:    return 8'hF3;
      4'd2:    return 8'hC8;
      4'd3:    return 8'hF3;
      4'd4:    return 8'h64;
      4'd5:    return 8'hF3;
      4'd6:    return 8'h50;
      4'd7:    return 8'hF2;
      default: return 8'hF4;
    endcase
`else
    return (s == 4'd0) ? 8'hFF : 8'hF4;
`endif
  endfunction

  // Expected response byte r to the command of step s.
  function automatic logic [7:0] exp_of(input logic [3:0] s, input logic [1:0] r);
    if (s == 4'd0) begin
      case (r)
        2'd0:    return 8'hFA;
        2'd1:    return 8'hAA;
        default: return 8'h00;
      endcase
    end
    return 8'hFA;
  endfunction

  // Index of the final response byte of step s.
  function automatic logic [1:0] last_of(input logic [3:0] s);
    if (s == 4'd0) return 2'd2;
`ifdef MOUSE_WHEEL_EN
    if (s == ID_STEP) return 2'd1;
`endif
    return 2'd0;
  endfunction

  assign tmo    = (cnt_q == TIMEOUT_LAST);
  assign rx_err = (BYTE_ERROR_CODE != 2'b00);

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    resp_d   = resp_q;
    cnt_d    = cnt_q + CW'(1);
    send_d   = 1'b0;
    tx_d     = tx_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    status_d = status_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    dz_d     = dz_q;
    irq_d    = 1'b0;
    done_d   = done_q;
    wheel_d  = wheel_q;
    restart  = 1'b0;
    advance  = 1'b0;

    case (state_q)
      ST_STARTUP: begin
        if (cnt_q == STARTUP_LAST) begin
          state_d = ST_SEND;
          cnt_d   = '0;
        end
      end
      ST_SEND: begin
        send_d  = 1'b1;
        tx_d    = cmd_of(step_q);
        state_d = ST_WAIT_SENT;
        cnt_d   = '0;
      end
      ST_WAIT_SENT: begin
        if (BYTE_SENT) begin
          state_d = ST_WAIT_RESP;
          resp_d  = '0;
          cnt_d   = '0;
        end else if (tmo) begin
          restart = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        if (BYTE_READY) begin
          if (rx_err) begin
            restart = 1'b1;
`ifdef MOUSE_WHEEL_EN
          end else if (step_q == ID_STEP && resp_q == 2'd1) begin
            // ID 0x03 unlocks the wheel; ID 0x00 falls back to 3-byte packets.
            if (BYTE_READ == 8'h03) begin
              wheel_d = 1'b1;
              advance = 1'b1;
            end else if (BYTE_READ == 8'h00) begin
              wheel_d = 1'b0;
              advance = 1'b1;
            end else begin
              restart = 1'b1;
            end
`endif
          end else if (BYTE_READ != exp_of(step_q, resp_q)) begin
            restart = 1'b1;
          end else if (resp_q == last_of(step_q)) begin
            advance = 1'b1;
          end else begin
            resp_d = resp_q + 2'd1;
            cnt_d  = '0;
          end
        end else if (tmo) begin
          restart = 1'b1;
        end
      end
      ST_STREAM_B0: begin
        // No timeout while idle between packets; bit3 marks a valid first byte.
        cnt_d = '0;
        if (BYTE_READY && !rx_err && BYTE_READ[3]) begin
          sh0_d   = BYTE_READ;
          state_d = ST_STREAM_B1;
        end
      end
      ST_STREAM_B1: begin
        if (BYTE_READY) begin
          cnt_d = '0;
          if (rx_err) begin
            state_d = ST_STREAM_B0;
          end else begin
            sh1_d   = BYTE_READ;
            state_d = ST_STREAM_B2;
          end
        end else if (tmo) begin
          state_d = ST_STREAM_B0;
          cnt_d   = '0;
        end
      end
      ST_STREAM_B2: begin
        if (BYTE_READY) begin
          cnt_d = '0;
          if (rx_err) begin
            state_d = ST_STREAM_B0;
          end else if (wheel_q) begin
            sh2_d   = BYTE_READ;
            state_d = ST_STREAM_B3;
          end else begin
            status_d = sh0_q;
            dx_d     = sh1_q;
            dy_d     = BYTE_READ;
            dz_d     = 8'h00;
            irq_d    = 1'b1;
            state_d  = ST_STREAM_B0;
          end
        end else if (tmo) begin
          state_d = ST_STREAM_B0;
          cnt_d   = '0;
        end
      end
      ST_STREAM_B3: begin
        if (BYTE_READY) begin
          cnt_d   = '0;
          state_d = ST_STREAM_B0;
          if (!rx_err) begin
            status_d = sh0_q;
            dx_d     = sh1_q;
            dy_d     = sh2_q;
`ifdef MOUSE_WHEEL_EN
            dz_d     = {{4{BYTE_READ[3]}}, BYTE_READ[3:0]};
`else
            dz_d     = 8'h00;
`endif
            irq_d    = 1'b1;
          end
        end else if (tmo) begin
          state_d = ST_STREAM_B0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    // Any init fault re-issues the reset command without the power-up wait.
    if (restart) begin
      state_d = ST_SEND;
      step_d  = '0;
      resp_d  = '0;
      cnt_d   = '0;
      wheel_d = 1'b0;
      done_d  = 1'b0;
    end
    if (advance) begin
      cnt_d  = '0;
      resp_d = '0;
      if (step_q == LAST_STEP) begin
        state_d = ST_STREAM_B0;
        done_d  = 1'b1;
      end else begin
        step_d  = step_q + 4'd1;
        state_d = ST_SEND;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_STARTUP;
      step_q   <= '0;
      resp_q   <= '0;
      cnt_q    <= '0;
      send_q   <= 1'b0;
      tx_q     <= '0;
      sh0_q    <= '0;
      sh1_q    <= '0;
      sh2_q    <= '0;
      status_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      dz_q     <= '0;
      irq_q    <= 1'b0;
      done_q   <= 1'b0;
      wheel_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      resp_q   <= resp_d;
      cnt_q    <= cnt_d;
      send_q   <= send_d;
      tx_q     <= tx_d;
      sh0_q    <= sh0_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      status_q <= status_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      dz_q     <= dz_d;
      irq_q    <= irq_d;
      done_q   <= done_d;
      wheel_q  <= wheel_d;
    end
  end

  assign SEND_BYTE      = send_q;
  assign BYTE_TO_SEND   = tx_q;
  assign READ_ENABLE    = state_q inside {ST_WAIT_RESP, ST_STREAM_B0, ST_STREAM_B1,
                                          ST_STREAM_B2, ST_STREAM_B3};
  assign MOUSE_STATUS   = status_q;
  assign MOUSE_DX       = dx_q;
  assign MOUSE_DY       = dy_q;
  assign MOUSE_DZ       = dz_q;
  assign SEND_INTERRUPT = irq_q;
  assign INIT_DONE      = done_q;
  assign WHEEL_MODE     = wheel_q;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed self-checking bench for mouse_master_sm; follows MOUSE_WHEEL_EN.
module tb_mouse_master_sm;
  localparam int unsigned SC         = 20;
  localparam int unsigned TC         = 100;
  localparam int unsigned WAIT_LIMIT = 400;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ;
  logic       SEND_INTERRUPT, INIT_DONE, WHEEL_MODE;

  int unsigned total = 0, passes = 0, fails = 0;
  int unsigned irq_cnt = 0;
  bit          exp_wheel = 1'b0;
  logic [7:0]  exp_status = '0, exp_dx = '0, exp_dy = '0, exp_dz = '0;
`ifdef MOUSE_WHEEL_EN
  logic [7:0]  dev_id = 8'h03;
  logic [7:0]  wcmd [6] = '{8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50};
`endif

  mouse_master_sm #(.STARTUP_CYCLES(SC), .TIMEOUT_CYCLES(TC)) dut (
    .CLK(CLK), .RESET(RESET),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
    .MOUSE_DZ(MOUSE_DZ), .SEND_INTERRUPT(SEND_INTERRUPT),
    .INIT_DONE(INIT_DONE), .WHEEL_MODE(WHEEL_MODE)
  );

  always #5 CLK = ~CLK;

  // Count packet strobes.
  always @(negedge CLK) if (SEND_INTERRUPT === 1'b1) irq_cnt <= irq_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for a command, check it is held, then acknowledge it.
  task automatic wait_send(input logic [7:0] exp, input string tag, output int unsigned cyc);
    cyc = 0;
    while (SEND_BYTE !== 1'b1 && cyc < WAIT_LIMIT) begin
      @(negedge CLK);
      cyc++;
    end
    chk({tag, "_seen"}, 32'(cyc < WAIT_LIMIT), 32'd1);
    if (cyc < WAIT_LIMIT) begin
      chk({tag, "_byte"}, 32'(BYTE_TO_SEND), 32'(exp));
      chk({tag, "_ren"}, 32'(READ_ENABLE), 32'd0);
      @(negedge CLK);
      chk({tag, "_pulse"}, 32'(SEND_BYTE), 32'd0);
      repeat (2) @(negedge CLK);
      chk({tag, "_hold"}, 32'(BYTE_TO_SEND), 32'(exp));
      BYTE_SENT = 1'b1;
      @(negedge CLK);
      BYTE_SENT = 1'b0;
    end
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] e);
    BYTE_READ       = b;
    BYTE_ERROR_CODE = e;
    BYTE_READY      = 1'b1;
    @(negedge CLK);
    BYTE_READY      = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  // Everything after the 0xFF command has been acknowledged.
  task automatic init_rest();
    int unsigned c;
    rx(8'hFA, 2'b00);
    rx(8'hAA, 2'b00);
    rx(8'h00, 2'b00);
`ifdef MOUSE_WHEEL_EN
    for (int i = 0; i < 6; i++) begin
      wait_send(wcmd[i], "cmd_rate", c);
      rx(8'hFA, 2'b00);
    end
    wait_send(8'hF2, "cmd_f2", c);
    rx(8'hFA, 2'b00);
    rx(dev_id, 2'b00);
`endif
    wait_send(8'hF4, "cmd_f4", c);
    chk("pre_done", 32'(INIT_DONE), 32'd0);
    rx(8'hFA, 2'b00);
    chk("init_done", 32'(INIT_DONE), 32'd1);
    chk("stream_ren", 32'(READ_ENABLE), 32'd1);
    chk("wheel_mode", 32'(WHEEL_MODE), 32'(exp_wheel));
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] b [4]);
    int unsigned i0;
    i0 = irq_cnt;
    rx(b[0], 2'b00);
    rx(b[1], 2'b00);
    chk({tag, "_hold"}, 32'(MOUSE_STATUS), 32'(exp_status));
    rx(b[2], 2'b00);
    if (exp_wheel) rx(b[3], 2'b00);
    #1;
    exp_status = b[0];
    exp_dx     = b[1];
    exp_dy     = b[2];
    exp_dz     = exp_wheel ? {{4{b[3][3]}}, b[3][3:0]} : 8'h00;
    chk({tag, "_status"}, 32'(MOUSE_STATUS), 32'(exp_status));
    chk({tag, "_dx"}, 32'(MOUSE_DX), 32'(exp_dx));
    chk({tag, "_dy"}, 32'(MOUSE_DY), 32'(exp_dy));
    chk({tag, "_dz"}, 32'(MOUSE_DZ), 32'(exp_dz));
    chk({tag, "_irq"}, 32'(irq_cnt - i0), 32'd1);
  endtask

  initial begin
    int unsigned c;
    int unsigned i0;
    logic [7:0] p [4];

    BYTE_SENT = 1'b0; BYTE_READY = 1'b0; BYTE_READ = '0; BYTE_ERROR_CODE = '0;
    repeat (3) @(negedge CLK);
    chk("rst_send", 32'(SEND_BYTE), 32'd0);
    chk("rst_tx", 32'(BYTE_TO_SEND), 32'd0);
    chk("rst_ren", 32'(READ_ENABLE), 32'd0);
    chk("rst_done", 32'(INIT_DONE), 32'd0);
    chk("rst_wheel", 32'(WHEEL_MODE), 32'd0);
    chk("rst_status", 32'(MOUSE_STATUS), 32'd0);
    chk("rst_irq", 32'(SEND_INTERRUPT), 32'd0);

    // Clean initialisation.
`ifdef MOUSE_WHEEL_EN
    exp_wheel = 1'b1;
`endif
    RESET = 1'b1;
    wait_send(8'hFF, "cmd_ff", c);
    chk("startup_wait", 32'(c >= SC), 32'd1);
    init_rest();

    // Packets: DZ = -1 from 0x0F, then DZ = +7.
    p = '{8'h09, 8'h1E, 8'h2D, 8'h0F};
    send_pkt("pkt1", p);
    p = '{8'h08, 8'hFF, 8'h01, 8'h07};
    send_pkt("pkt2", p);

    // Stray byte without bit3 must not start a packet.
    rx(8'h00, 2'b00);
    p = '{8'h38, 8'h05, 8'hFB, 8'h0E};
    send_pkt("pkt_resync", p);

    // Parity error on byte 2 discards the packet.
    i0 = irq_cnt;
    rx(8'h18, 2'b00);
    rx(8'h10, 2'b01);
    repeat (2) @(negedge CLK);
    chk("err_irq", 32'(irq_cnt - i0), 32'd0);
    chk("err_status", 32'(MOUSE_STATUS), 32'(exp_status));
    chk("err_dx", 32'(MOUSE_DX), 32'(exp_dx));

    // Inter-byte timeout drops a partial packet.
    rx(8'h28, 2'b00);
    repeat (TC + 10) @(negedge CLK);
    chk("tmo_irq", 32'(irq_cnt - i0), 32'd0);
    chk("tmo_status", 32'(MOUSE_STATUS), 32'(exp_status));
    p = '{8'h09, 8'h11, 8'h22, 8'h01};
    send_pkt("pkt_after_tmo", p);

    // Init faults: 0xFE reply, then silence.
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    exp_status = '0; exp_dx = '0; exp_dy = '0; exp_dz = '0;
    wait_send(8'hFF, "fault_ff", c);
    rx(8'hFE, 2'b00);
    wait_send(8'hFF, "resend_nak", c);
    chk("nak_no_startup", 32'(c < SC), 32'd1);
    chk("nak_done", 32'(INIT_DONE), 32'd0);
    wait_send(8'hFF, "resend_tmo", c);
    chk("tmo_wait", 32'(c >= TC - 2 && c < TC + 10), 32'd1);
    chk("tmo_done", 32'(INIT_DONE), 32'd0);
`ifdef MOUSE_WHEEL_EN
    dev_id    = 8'h00;
`endif
    exp_wheel = 1'b0;
    init_rest();
    p = '{8'h09, 8'h1E, 8'h2D, 8'h0F};
    send_pkt("pkt_3byte", p);

    // Reset in the middle of a packet clears everything at once.
    rx(8'h28, 2'b00);
    rx(8'h44, 2'b00);
    RESET = 1'b0;
    #1;
    chk("midrst_status", 32'(MOUSE_STATUS), 32'd0);
    chk("midrst_dx", 32'(MOUSE_DX), 32'd0);
    chk("midrst_dy", 32'(MOUSE_DY), 32'd0);
    chk("midrst_done", 32'(INIT_DONE), 32'd0);
    chk("midrst_ren", 32'(READ_ENABLE), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    wait_send(8'hFF, "post_rst_ff", c);
    chk("post_rst_wait", 32'(c >= SC), 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
